// File: rtl/client_pack_pkg.sv
// Shared types and sizing for the client transmit packet buffer.
package client_pack_pkg;
    localparam int AW      = 9;
    localparam int MIN_LEN = 60;

    typedef enum logic [1:0] {IDLE, FILL, LOAD, SEND} state_t;

    // Write-side view of whichever client currently owns the buffer
    typedef struct packed {
        logic       strobe;
        logic [7:0] data;
        logic       done;
    } wr_req_t;
endpackage

// File: rtl/client_pack_tx_if.sv
// Client write ports and PSPEPS Tx handshake of the transmit packet buffer.
interface client_pack_tx_if;
    import client_pack_pkg::*;

    logic          pack1_req, pack2_req;
    logic          pack1_grant, pack2_grant;
    logic          pack1_write_strobe, pack2_write_strobe;
    logic [7:0]    pack1_data_in, pack2_data_in;
    logic          pack1_write_done, pack2_write_done;
    logic          tx_req;
    logic          tx_which;
    logic [AW-1:0] tx_len;
    logic          tx_strobe;
    logic [7:0]    tx_data;

    // slave: the buffer itself; master: clients plus Tx engine
    modport slave (
        input  pack1_req, pack2_req, pack1_write_strobe, pack2_write_strobe,
               pack1_data_in, pack2_data_in, pack1_write_done, pack2_write_done, tx_strobe,
        output pack1_grant, pack2_grant, tx_req, tx_which, tx_len, tx_data
    );
    modport master (
        output pack1_req, pack2_req, pack1_write_strobe, pack2_write_strobe,
               pack1_data_in, pack2_data_in, pack1_write_done, pack2_write_done, tx_strobe,
        input  pack1_grant, pack2_grant, tx_req, tx_which, tx_len, tx_data
    );
endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: port a writes, port b reads with a registered output.
module dpram #(
    parameter int aw = 9,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] din_a,
    input  logic          we_a,
    input  logic [aw-1:0] addr_b,
    output logic [dw-1:0] dout_b
);
    logic [dw-1:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/client_pack_tx.sv
// Transmit packet buffer: arbitrates two clients into a 512x8 DPRAM, then streams to PSPEPS Tx.
// Optional CLIENT_PACK_TX_PAD_EN pads short frames to MIN_LEN with zero bytes.
module client_pack_tx
    import client_pack_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    client_pack_tx_if.slave bus,
    output logic            busy
);
    state_t        state, state_nxt;
    wr_req_t       wreq;
    logic [1:0]    grant_q;
    logic          cur_port, last_served, which_q;
    logic [AW-1:0] wr_ptr, rd_ptr, len_q, wr_cnt, rd_addr;
    logic          wr_en, grant_en, done_en, last_rd, pick;
    logic [7:0]    ram_q;

    always_comb begin
        wreq = cur_port ? '{strobe: bus.pack2_write_strobe, data: bus.pack2_data_in, done: bus.pack2_write_done}
                        : '{strobe: bus.pack1_write_strobe, data: bus.pack1_data_in, done: bus.pack1_write_done};
    end

    // Address 2^AW-1 is never written, so a full buffer holds 511 bytes
    assign wr_en   = (state == FILL) && wreq.strobe && (wr_ptr != '1);
    assign wr_cnt  = wr_ptr + AW'(wr_en);
    assign pick    = (bus.pack1_req && bus.pack2_req) ? ~last_served : bus.pack2_req;
    assign rd_addr = (state == SEND && bus.tx_strobe) ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        done_en   = 1'b0;
        last_rd   = 1'b0;
        case (state)
            IDLE: if (bus.pack1_req || bus.pack2_req) begin
                grant_en  = 1'b1;
                state_nxt = FILL;
            end
            FILL: if (wreq.done) begin
                done_en   = 1'b1;
                state_nxt = (wr_cnt == '0) ? IDLE : LOAD;
            end
            LOAD: state_nxt = SEND;
            SEND: if (bus.tx_strobe && rd_ptr == len_q - AW'(1)) begin
                last_rd   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

`ifdef CLIENT_PACK_TX_PAD_EN
    logic [AW-1:0] wr_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wr_len <= '0;
        else if (done_en) wr_len <= wr_cnt;
    end

    // Bytes past the written length read as zero; the RAM is never cleared
    assign bus.tx_data = (state == SEND && rd_ptr < wr_len) ? ram_q : 8'h00;
`else
    assign bus.tx_data = (state == SEND) ? ram_q : 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            cur_port    <= 1'b0;
            last_served <= 1'b1;
            which_q     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len_q       <= '0;
        end else begin
            if (grant_en) begin
                grant_q  <= pick ? 2'b10 : 2'b01;
                cur_port <= pick;
                wr_ptr   <= '0;
            end
            if (wr_en) wr_ptr <= wr_cnt;
            if (done_en) begin
                grant_q <= '0;
                which_q <= cur_port;
                rd_ptr  <= '0;
`ifdef CLIENT_PACK_TX_PAD_EN
                len_q   <= (wr_cnt < AW'(MIN_LEN)) ? AW'(MIN_LEN) : wr_cnt;
`else
                len_q   <= wr_cnt;
`endif
            end
            if (state == SEND && bus.tx_strobe) rd_ptr <= rd_ptr + AW'(1);
            if (last_rd) last_served <= which_q;
        end
    end

    assign bus.pack1_grant = grant_q[0];
    assign bus.pack2_grant = grant_q[1];
    assign bus.tx_req      = (state == SEND);
    assign bus.tx_which    = which_q;
    assign bus.tx_len      = len_q;
    assign busy            = (state != IDLE);

    dpram #(.aw(AW), .dw(8)) u_ram (
        .clk    (clk),
        .addr_a (wr_ptr),
        .din_a  (wreq.data),
        .we_a   (wr_en),
        .addr_b (rd_addr),
        .dout_b (ram_q)
    );
endmodule

// File: tb/tb_client_pack_tx.sv
// Directed bench for client_pack_tx: arbitration, fill, streaming, saturation, padding, reset.
module tb_client_pack_tx;
    import client_pack_pkg::*;

    logic clk, rst_n, busy;
    int   n_chk = 0, n_err = 0;
    logic [7:0] exp_q [0:511];

    client_pack_tx_if bus();
    client_pack_tx dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic int elen(input int n);
`ifdef CLIENT_PACK_TX_PAD_EN
        return (n < MIN_LEN) ? MIN_LEN : n;
`else
        return n;
`endif
    endfunction

    task automatic set_pad(input int n);
        for (int i = n; i < elen(n); i++) exp_q[i] = 8'h00;
    endtask

    task automatic put(input int port, input logic stb, input logic [7:0] d, input logic dn);
        if (port == 1) begin
            bus.pack1_write_strobe = stb; bus.pack1_data_in = d; bus.pack1_write_done = dn;
        end else begin
            bus.pack2_write_strobe = stb; bus.pack2_data_in = d; bus.pack2_write_done = dn;
        end
    endtask

    task automatic do_reset(input string tag);
        bus.pack1_req = 0; bus.pack2_req = 0; bus.tx_strobe = 0;
        put(1, 0, 8'h00, 0); put(2, 0, 8'h00, 0);
        rst_n = 0;
        #2;
        chk({tag, " grant1"}, bus.pack1_grant, 0);
        chk({tag, " grant2"}, bus.pack2_grant, 0);
        chk({tag, " tx_req"}, bus.tx_req, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " tx_len"}, bus.tx_len, 0);
        chk({tag, " tx_which"}, bus.tx_which, 0);
        chk({tag, " tx_data"}, bus.tx_data, 0);
        @(negedge clk); rst_n = 1;
        tick();
    endtask

    task automatic get_grant(input int port, input string tag);
        if (port == 1) bus.pack1_req = 1; else bus.pack2_req = 1;
        tick();
        chk({tag, " grant1"}, bus.pack1_grant, (port == 1));
        chk({tag, " grant2"}, bus.pack2_grant, (port == 2));
        bus.pack1_req = 0; bus.pack2_req = 0;
    endtask

    // Writes n bytes base+i; done rides on the last strobe or follows it
    task automatic fill(input int port, input int n, input int base, input bit done_last);
        for (int i = 0; i < n; i++) begin
            put(port, 1, 8'(base + i), done_last && (i == n - 1));
            if (i < 512) exp_q[i] = 8'(base + i);
            tick();
        end
        if (!done_last || n == 0) begin
            put(port, 0, 8'h00, 1);
            tick();
        end
        put(port, 0, 8'h00, 0);
    endtask

    task automatic recv(input int n, input string tag);
        bus.tx_strobe = 1;
        for (int i = 0; i < n; i++) begin
            chk({tag, " req"}, bus.tx_req, 1);
            chk($sformatf("%s byte%0d", tag, i), bus.tx_data, exp_q[i]);
            tick();
        end
        bus.tx_strobe = 0;
        chk({tag, " req_end"}, bus.tx_req, 0);
    endtask

    initial begin
        rst_n = 1;
        do_reset("rst0");

        // Basic 5-byte packet, done together with the last strobe
        get_grant(1, "t1");
        fill(1, 5, 'h11, 1);
        set_pad(5);
        chk("t1 grant_off", bus.pack1_grant, 0);
        chk("t1 load_noreq", bus.tx_req, 0);
        chk("t1 busy", busy, 1);
        chk("t1 len", bus.tx_len, elen(5));
        chk("t1 which", bus.tx_which, 0);
        tick();
        recv(elen(5), "t1");
        chk("t1 idle", busy, 0);

        // Tie from reset goes to port 1, then port 2 after L+2
        do_reset("rst1");
        bus.pack1_req = 1; bus.pack2_req = 1;
        tick();
        chk("t2 tie g1", bus.pack1_grant, 1);
        chk("t2 tie g2", bus.pack2_grant, 0);
        fill(1, 2, 'h21, 0);
        set_pad(2);
        tick();
        recv(elen(2), "t2a");
        chk("t2 L1 g1", bus.pack1_grant, 0);
        chk("t2 L1 g2", bus.pack2_grant, 0);
        tick();
        chk("t2 L2 g1", bus.pack1_grant, 0);
        chk("t2 L2 g2", bus.pack2_grant, 1);
        bus.pack1_req = 0; bus.pack2_req = 0;
        fill(2, 1, 'hA5, 1);
        set_pad(1);
        chk("t2 which", bus.tx_which, 1);
        chk("t2 len", bus.tx_len, elen(1));
        tick();
        recv(elen(1), "t2b");

        // Non-granted strobes ignored, then an empty packet is discarded
        get_grant(1, "t3");
        put(1, 1, 8'h31, 0); put(2, 1, 8'hE0, 0); tick();
        put(1, 0, 8'h00, 0); put(2, 1, 8'hE1, 0); tick();
        put(1, 1, 8'h32, 0); put(2, 1, 8'hE2, 0); tick();
        put(2, 0, 8'h00, 0); put(1, 0, 8'h00, 1); tick();
        put(1, 0, 8'h00, 0);
        exp_q[0] = 8'h31; exp_q[1] = 8'h32;
        set_pad(2);
        chk("t3 len", bus.tx_len, elen(2));
        chk("t3 which", bus.tx_which, 0);
        tick();
        recv(elen(2), "t3");
        get_grant(1, "t3e");
        fill(1, 0, 0, 0);
        chk("t3e req", bus.tx_req, 0);
        chk("t3e busy", busy, 0);
        chk("t3e grant", bus.pack1_grant, 0);
        tick();
        chk("t3e req2", bus.tx_req, 0);

        // Overflow: 520 strobes saturate at 511 bytes
        get_grant(2, "t4");
        fill(2, 520, 0, 0);
        chk("t4 len", bus.tx_len, 511);
        chk("t4 which", bus.tx_which, 1);
        tick();
        recv(511, "t4");

        // Short frame: padded only when the pad option is built in
        get_grant(1, "t5");
        fill(1, 10, 'h50, 0);
        set_pad(10);
        chk("t5 len", bus.tx_len, elen(10));
        tick();
        recv(elen(10), "t5");

        // Reset mid-SEND, then a fresh 2-byte packet
        get_grant(1, "t6");
        fill(1, 8, 'h61, 0);
        tick();
        bus.tx_strobe = 1;
        repeat (3) tick();
        bus.tx_strobe = 0;
        chk("t6 pre req", bus.tx_req, 1);
        chk("t6 pre data", bus.tx_data, 8'h64);
        do_reset("t6rst");
        get_grant(2, "t6b");
        fill(2, 2, 'h71, 0);
        set_pad(2);
        chk("t6b len", bus.tx_len, elen(2));
        chk("t6b which", bus.tx_which, 1);
        tick();
        recv(elen(2), "t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
